// File: rtl/csi2_stat_mon.sv
// csi2_stat_mon: per-virtual-channel CSI-2 receive statistics (line length,
// lines per frame, frame count) plus global header/corrected-header/CRC error
// counters. All values saturate at all-ones.
// Build option CSI2_STAT_SNAPSHOT_EN: the eight outputs come from a shadow bank
// that is only reloaded when snapshot_i is high; otherwise outputs are live.
module csi2_stat_mon #(
  parameter int CNT_WIDTH = 32,
  parameter int VC_CNT    = 4,
  parameter int ERR_DLY   = 2,
  parameter int VC_W      = (VC_CNT > 1) ? $clog2(VC_CNT) : 1
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 video_data_val_i,
  input  logic                 video_proc_ready_i,
  input  logic                 video_eol_i,
  input  logic                 video_frame_start_i,
  input  logic [VC_W-1:0]      video_vc_i,
  input  logic                 header_err_i,
  input  logic                 corr_header_err_i,
  input  logic                 crc_err_i,
  input  logic                 clear_stat_i,
  input  logic [VC_W-1:0]      stat_vc_sel_i,
  input  logic                 snapshot_i,
  output logic [CNT_WIDTH-1:0] header_err_cnt_o,
  output logic [CNT_WIDTH-1:0] corr_header_err_cnt_o,
  output logic [CNT_WIDTH-1:0] crc_err_cnt_o,
  output logic [CNT_WIDTH-1:0] max_px_per_ln_o,
  output logic [CNT_WIDTH-1:0] min_px_per_ln_o,
  output logic [CNT_WIDTH-1:0] max_ln_per_frame_o,
  output logic [CNT_WIDTH-1:0] min_ln_per_frame_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [VC_W:0]        VC_LIMIT = (VC_W+1)'(VC_CNT);

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_ONES) ? v : v + CNT_ONE;
  endfunction

  // ---------------- error pulse delay and counting ----------------
  logic [2:0]           err_pipe_reg [ERR_DLY];
  logic [2:0]           err_dly;
  logic [CNT_WIDTH-1:0] hdr_cnt_reg, corr_cnt_reg, crc_cnt_reg;

  assign err_dly = err_pipe_reg[ERR_DLY-1];

  // Delay line for {crc, corr_header, header} pulses; clear drops anything in flight.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i || clear_stat_i) begin
      for (int i = 0; i < ERR_DLY; i++) err_pipe_reg[i] <= '0;
    end else begin
      err_pipe_reg[0] <= {crc_err_i, corr_header_err_i, header_err_i};
      for (int i = 1; i < ERR_DLY; i++) err_pipe_reg[i] <= err_pipe_reg[i-1];
    end
  end

  // Global error counters, each counted independently of the others.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      hdr_cnt_reg  <= '0;
      corr_cnt_reg <= '0;
      crc_cnt_reg  <= '0;
    end else if (clear_stat_i) begin
      hdr_cnt_reg  <= '0;
      corr_cnt_reg <= '0;
      crc_cnt_reg  <= '0;
    end else begin
      if (err_dly[0]) hdr_cnt_reg  <= sat_inc(hdr_cnt_reg);
      if (err_dly[1]) corr_cnt_reg <= sat_inc(corr_cnt_reg);
      if (err_dly[2]) crc_cnt_reg  <= sat_inc(crc_cnt_reg);
    end
  end

  // ---------------- per-VC video statistics ----------------
  logic                 beat_acc;
  logic [CNT_WIDTH-1:0] vc_max_px [VC_CNT];
  logic [CNT_WIDTH-1:0] vc_min_px [VC_CNT];
  logic [CNT_WIDTH-1:0] vc_max_ln [VC_CNT];
  logic [CNT_WIDTH-1:0] vc_min_ln [VC_CNT];
  logic [CNT_WIDTH-1:0] vc_frames [VC_CNT];

  // Beats on untracked channels are dropped here so no VC ever sees them.
  assign beat_acc = video_data_val_i && video_proc_ready_i && ({1'b0, video_vc_i} < VC_LIMIT);

  for (genvar gi = 0; gi < VC_CNT; gi++) begin : g_vc
    logic                 hit;
    logic [CNT_WIDTH-1:0] line_len;
    logic [CNT_WIDTH-1:0] px_cnt_reg, ln_cnt_reg;
    logic [CNT_WIDTH-1:0] max_px_reg, min_px_reg, max_ln_reg, min_ln_reg, frame_cnt_reg;
    logic                 frame_seen_reg;

    assign hit      = beat_acc && (video_vc_i == VC_W'(gi));
    assign line_len = sat_inc(px_cnt_reg);

    // Position within the current line and frame; keeps running through clear.
    always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
        px_cnt_reg <= '0;
        ln_cnt_reg <= '0;
      end else if (hit) begin
        px_cnt_reg <= video_eol_i ? '0 : sat_inc(px_cnt_reg);
        if (video_frame_start_i)
          ln_cnt_reg <= video_eol_i ? CNT_ONE : '0;
        else if (video_eol_i)
          ln_cnt_reg <= sat_inc(ln_cnt_reg);
      end
    end

    // Line/frame extremes and frame count; a partial first frame is never recorded.
    always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i || clear_stat_i) begin
        max_px_reg     <= '0;
        min_px_reg     <= CNT_ONES;
        max_ln_reg     <= '0;
        min_ln_reg     <= CNT_ONES;
        frame_cnt_reg  <= '0;
        frame_seen_reg <= 1'b0;
      end else if (hit) begin
        if (video_eol_i) begin
          if (line_len > max_px_reg) max_px_reg <= line_len;
          if (line_len < min_px_reg) min_px_reg <= line_len;
        end
        if (video_frame_start_i) begin
          if (frame_seen_reg) begin
            if (ln_cnt_reg > max_ln_reg) max_ln_reg <= ln_cnt_reg;
            if (ln_cnt_reg < min_ln_reg) min_ln_reg <= ln_cnt_reg;
            frame_cnt_reg <= sat_inc(frame_cnt_reg);
          end
          frame_seen_reg <= 1'b1;
        end
      end
    end

    assign vc_max_px[gi] = max_px_reg;
    assign vc_min_px[gi] = min_px_reg;
    assign vc_max_ln[gi] = max_ln_reg;
    assign vc_min_ln[gi] = min_ln_reg;
    assign vc_frames[gi] = frame_cnt_reg;
  end

  // ---------------- readback ----------------
  logic [CNT_WIDTH-1:0] sel_max_px, sel_min_px, sel_max_ln, sel_min_ln, sel_frames;
  logic                 out_load;

  // Per-VC readback mux; an untracked selection reads as all zeros.
  always_comb begin
    sel_max_px = '0;
    sel_min_px = '0;
    sel_max_ln = '0;
    sel_min_ln = '0;
    sel_frames = '0;
    for (int i = 0; i < VC_CNT; i++) begin
      if (stat_vc_sel_i == VC_W'(i)) begin
        sel_max_px = vc_max_px[i];
        sel_min_px = vc_min_px[i];
        sel_max_ln = vc_max_ln[i];
        sel_min_ln = vc_min_ln[i];
        sel_frames = vc_frames[i];
      end
    end
  end

`ifdef CSI2_STAT_SNAPSHOT_EN
  assign out_load = snapshot_i;
`else
  // Live outputs: the snapshot request has no effect in this build.
  logic snapshot_unused;
  assign snapshot_unused = snapshot_i;
  assign out_load        = 1'b1;
`endif

  // Output register bank: live copy every cycle, or shadow loaded on snapshot.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      header_err_cnt_o      <= '0;
      corr_header_err_cnt_o <= '0;
      crc_err_cnt_o         <= '0;
      max_px_per_ln_o       <= '0;
      min_px_per_ln_o       <= CNT_ONES;
      max_ln_per_frame_o    <= '0;
      min_ln_per_frame_o    <= CNT_ONES;
      frame_cnt_o           <= '0;
    end else if (out_load) begin
      header_err_cnt_o      <= hdr_cnt_reg;
      corr_header_err_cnt_o <= corr_cnt_reg;
      crc_err_cnt_o         <= crc_cnt_reg;
      max_px_per_ln_o       <= sel_max_px;
      min_px_per_ln_o       <= sel_min_px;
      max_ln_per_frame_o    <= sel_max_ln;
      min_ln_per_frame_o    <= sel_min_ln;
      frame_cnt_o           <= sel_frames;
    end
  end

endmodule

// File: tb/tb_csi2_stat_mon.sv
// tb_csi2_stat_mon: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the statistics monitor.
module tb_csi2_stat_mon;
  localparam int CW   = 8;
  localparam int NVC  = 3;
  localparam int DLY  = 2;
  localparam int VW   = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          srst_i = 1'b1;
  logic          video_data_val_i = 1'b0, video_proc_ready_i = 1'b0;
  logic          video_eol_i = 1'b0, video_frame_start_i = 1'b0;
  logic [VW-1:0] video_vc_i = '0;
  logic          header_err_i = 1'b0, corr_header_err_i = 1'b0, crc_err_i = 1'b0;
  logic          clear_stat_i = 1'b0;
  logic [VW-1:0] stat_vc_sel_i = '0;
  logic          snapshot_i = 1'b0;
  logic [CW-1:0] header_err_cnt_o, corr_header_err_cnt_o, crc_err_cnt_o;
  logic [CW-1:0] max_px_per_ln_o, min_px_per_ln_o, max_ln_per_frame_o, min_ln_per_frame_o, frame_cnt_o;

  csi2_stat_mon #(.CNT_WIDTH(CW), .VC_CNT(NVC), .ERR_DLY(DLY)) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .video_data_val_i(video_data_val_i), .video_proc_ready_i(video_proc_ready_i),
    .video_eol_i(video_eol_i), .video_frame_start_i(video_frame_start_i),
    .video_vc_i(video_vc_i),
    .header_err_i(header_err_i), .corr_header_err_i(corr_header_err_i), .crc_err_i(crc_err_i),
    .clear_stat_i(clear_stat_i), .stat_vc_sel_i(stat_vc_sel_i), .snapshot_i(snapshot_i),
    .header_err_cnt_o(header_err_cnt_o), .corr_header_err_cnt_o(corr_header_err_cnt_o),
    .crc_err_cnt_o(crc_err_cnt_o),
    .max_px_per_ln_o(max_px_per_ln_o), .min_px_per_ln_o(min_px_per_ln_o),
    .max_ln_per_frame_o(max_ln_per_frame_o), .min_ln_per_frame_o(min_ln_per_frame_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_hdr, m_corr, m_crc;
  bit [2:0] err_q[$];
  int       m_px[NVC], m_ln[NVC], m_maxpx[NVC], m_minpx[NVC], m_maxln[NVC], m_minln[NVC], m_fcnt[NVC];
  bit       m_seen[NVC];
  int       e_hdr = 0, e_corr = 0, e_crc = 0;
  int       e_maxpx = 0, e_minpx = MAXV, e_maxln = 0, e_minln = MAXV, e_fcnt = 0;

  function automatic int sat(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  task automatic clear_vc_stats();
    for (int v = 0; v < NVC; v++) begin
      m_maxpx[v] = 0; m_minpx[v] = MAXV; m_maxln[v] = 0; m_minln[v] = MAXV;
      m_fcnt[v] = 0; m_seen[v] = 0;
    end
  endtask

  task automatic model_reset();
    m_hdr = 0; m_corr = 0; m_crc = 0;
    err_q.delete();
    for (int i = 0; i < DLY; i++) err_q.push_back(3'b000);
    for (int v = 0; v < NVC; v++) begin m_px[v] = 0; m_ln[v] = 0; end
    clear_vc_stats();
    e_hdr = 0; e_corr = 0; e_crc = 0;
    e_maxpx = 0; e_minpx = MAXV; e_maxln = 0; e_minln = MAXV; e_fcnt = 0;
  endtask

  always @(posedge clk_i) begin : model
    bit       load;
    bit [2:0] e;
    int       v, len;
    if (srst_i) begin
      model_reset();
    end else begin
`ifdef CSI2_STAT_SNAPSHOT_EN
      load = snapshot_i;
`else
      load = 1'b1;
`endif
      // outputs show the state as it stood before this edge
      if (load) begin
        e_hdr = m_hdr; e_corr = m_corr; e_crc = m_crc;
        if (int'(stat_vc_sel_i) < NVC) begin
          v = int'(stat_vc_sel_i);
          e_maxpx = m_maxpx[v]; e_minpx = m_minpx[v];
          e_maxln = m_maxln[v]; e_minln = m_minln[v]; e_fcnt = m_fcnt[v];
        end else begin
          e_maxpx = 0; e_minpx = 0; e_maxln = 0; e_minln = 0; e_fcnt = 0;
        end
      end
      // errors: a pulse counts DLY edges after it was sampled unless a clear intervenes
      if (clear_stat_i) begin
        m_hdr = 0; m_corr = 0; m_crc = 0;
        err_q.delete();
        for (int i = 0; i < DLY; i++) err_q.push_back(3'b000);
      end else begin
        e = err_q.pop_front();
        m_hdr  = sat(m_hdr + int'(e[0]));
        m_corr = sat(m_corr + int'(e[1]));
        m_crc  = sat(m_crc + int'(e[2]));
        err_q.push_back({crc_err_i, corr_header_err_i, header_err_i});
      end
      // video
      if (video_data_val_i && video_proc_ready_i && int'(video_vc_i) < NVC) begin
        v = int'(video_vc_i);
        if (video_eol_i) begin
          len = sat(m_px[v] + 1);
          if (len > m_maxpx[v]) m_maxpx[v] = len;
          if (len < m_minpx[v]) m_minpx[v] = len;
          m_px[v] = 0;
        end else begin
          m_px[v] = sat(m_px[v] + 1);
        end
        if (video_frame_start_i) begin
          if (m_seen[v]) begin
            if (m_ln[v] > m_maxln[v]) m_maxln[v] = m_ln[v];
            if (m_ln[v] < m_minln[v]) m_minln[v] = m_ln[v];
            m_fcnt[v] = sat(m_fcnt[v] + 1);
          end
          m_seen[v] = 1;
          m_ln[v] = video_eol_i ? 1 : 0;
        end else if (video_eol_i) begin
          m_ln[v] = sat(m_ln[v] + 1);
        end
      end
      if (clear_stat_i) clear_vc_stats();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (!srst_i) begin
      chk("cyc/hdr_cnt",  int'(header_err_cnt_o),      e_hdr);
      chk("cyc/corr_cnt", int'(corr_header_err_cnt_o), e_corr);
      chk("cyc/crc_cnt",  int'(crc_err_cnt_o),         e_crc);
      chk("cyc/max_px",   int'(max_px_per_ln_o),       e_maxpx);
      chk("cyc/min_px",   int'(min_px_per_ln_o),       e_minpx);
      chk("cyc/max_ln",   int'(max_ln_per_frame_o),    e_maxln);
      chk("cyc/min_ln",   int'(min_ln_per_frame_o),    e_minln);
      chk("cyc/frames",   int'(frame_cnt_o),           e_fcnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(negedge clk_i);
    video_data_val_i = 0; video_proc_ready_i = 0; video_eol_i = 0; video_frame_start_i = 0;
    header_err_i = 0; corr_header_err_i = 0; crc_err_i = 0;
    clear_stat_i = 0; snapshot_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic view();
`ifdef CSI2_STAT_SNAPSHOT_EN
    snapshot_i = 1;
`endif
    cycle();
  endtask

  task automatic do_reset();
    #2 srst_i = 1;
    cycle();
    cycle();
    srst_i = 0;
  endtask

  task automatic send_line(input int vc, input int n, input bit fs);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        // a beat that must be ignored (not valid, or not ready)
        video_data_val_i    = 1'($urandom_range(0, 1));
        video_proc_ready_i  = ~video_data_val_i;
        video_vc_i          = VW'(vc);
        video_eol_i         = 1'($urandom_range(0, 1));
        video_frame_start_i = 1'($urandom_range(0, 1));
        cycle();
      end
      video_data_val_i    = 1;
      video_proc_ready_i  = 1;
      video_vc_i          = VW'(vc);
      video_frame_start_i = fs && (i == 0);
      video_eol_i         = (i == n - 1);
      cycle();
    end
  endtask

  task automatic chk_vc(input string tag, input int sel, input int mxp, input int mnp,
                        input int mxl, input int mnl, input int fc);
    stat_vc_sel_i = VW'(sel);
    view();
    chk({tag, "/max_px"}, int'(max_px_per_ln_o),    mxp);
    chk({tag, "/min_px"}, int'(min_px_per_ln_o),    mnp);
    chk({tag, "/max_ln"}, int'(max_ln_per_frame_o), mxl);
    chk({tag, "/min_ln"}, int'(min_ln_per_frame_o), mnl);
    chk({tag, "/frames"}, int'(frame_cnt_o),        fc);
  endtask

  task automatic chk_err(input string tag, input int h, input int c, input int r);
    view();
    chk({tag, "/hdr"},  int'(header_err_cnt_o),      h);
    chk({tag, "/corr"}, int'(corr_header_err_cnt_o), c);
    chk({tag, "/crc"},  int'(crc_err_cnt_o),         r);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(negedge clk_i);
    srst_i = 0;
    chk_vc("reset", 0, 0, MAXV, 0, MAXV, 0);
    chk_err("reset", 0, 0, 0);

    // VC0: three 4x10 frames, then a fourth frame start
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < 4; l++) send_line(0, 10, l == 0);
    video_data_val_i = 1; video_proc_ready_i = 1; video_vc_i = 0; video_frame_start_i = 1;
    cycle();
    chk_vc("vc0_frames", 0, 10, 10, 4, 4, 3);

    // VC0 and VC1 interleaved, no cross-contamination
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < 2; l++) begin
        send_line(0, 10, l == 0);
        send_line(1, 6, l == 0);
      end
    send_line(0, 1, 1'b0);  // stray one-pixel line, discarded by the reset below
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < 2; l++) begin
        send_line(0, 10, l == 0);
        send_line(1, 6, l == 0);
      end
    for (int v = 0; v < 2; v++) begin
      video_data_val_i = 1; video_proc_ready_i = 1; video_vc_i = VW'(v); video_frame_start_i = 1;
      cycle();
    end
    chk_vc("ilv_vc0", 0, 10, 10, 2, 2, 3);
    chk_vc("ilv_vc1", 1, 6, 6, 2, 2, 3);
    chk_vc("sel_oob", 3, 0, 0, 0, 0, 0);

    // VC2 lines 5,12,8 then clear, then a one-pixel frame
    do_reset();
    send_line(2, 5, 1'b1);
    send_line(2, 12, 1'b0);
    send_line(2, 8, 1'b0);
    chk_vc("vc2_lines", 2, 12, 5, 0, MAXV, 0);
    clear_stat_i = 1;
    cycle();
    chk_vc("vc2_clear", 2, 0, MAXV, 0, MAXV, 0);
    send_line(2, 1, 1'b1);
    chk_vc("vc2_one_px", 2, 1, 1, 0, MAXV, 0);

    // error pulse latency and independent counters
    clear_stat_i = 1;
    cycle();
    header_err_i = 1;
    cycle();
`ifndef CSI2_STAT_SNAPSHOT_EN
    cycle();
    cycle();
    chk("hdr_k+2", int'(header_err_cnt_o), 0);
    cycle();
    chk("hdr_k+3", int'(header_err_cnt_o), 1);
`else
    idle(3);
`endif
    corr_header_err_i = 1; crc_err_i = 1;
    cycle();
    idle(2);
    chk_err("simul", 1, 1, 1);

    // saturation and clear coincident with a pulse
    for (int i = 0; i < 300; i++) begin
      crc_err_i = 1;
      cycle();
    end
    idle(2);
    chk_err("crc_sat", 1, 1, MAXV);
    crc_err_i = 1; clear_stat_i = 1;
    cycle();
    idle(2);
    chk_err("clr_pulse", 0, 0, 0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      video_data_val_i    = ($urandom_range(0, 3) != 0);
      video_proc_ready_i  = ($urandom_range(0, 4) != 0);
      video_vc_i          = VW'($urandom_range(0, 3));
      video_eol_i         = ($urandom_range(0, 5) == 0);
      video_frame_start_i = ($urandom_range(0, 30) == 0);
      header_err_i        = ($urandom_range(0, 7) == 0);
      corr_header_err_i   = ($urandom_range(0, 7) == 0);
      crc_err_i           = ($urandom_range(0, 7) == 0);
      clear_stat_i        = ($urandom_range(0, 400) == 0);
      snapshot_i          = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) stat_vc_sel_i = VW'($urandom_range(0, 3));
      if (i == 2000) do_reset();
      else cycle();
    end

    // reset in the middle of a frame and a line
    send_line(0, 4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      video_data_val_i = 1; video_proc_ready_i = 1; video_vc_i = 0;
      header_err_i = 1;
      cycle();
    end
    do_reset();
    chk_vc("midrst", 0, 0, MAXV, 0, MAXV, 0);
    chk_err("midrst", 0, 0, 0);
    send_line(0, 3, 1'b0);
    chk_vc("post_rst_line", 0, 3, 3, 0, MAXV, 0);

`ifdef CSI2_STAT_SNAPSHOT_EN
    // shadow bank holds until the next snapshot request
    clear_stat_i = 1;
    cycle();
    idle(2);
    chk_err("snap_base", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      header_err_i = 1;
      cycle();
    end
    idle(4);
    chk("snap_hold", int'(header_err_cnt_o), 0);
    view();
    chk("snap_new", int'(header_err_cnt_o), 5);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csi2_stat_mon.md
# csi2_stat_mon

Multi-virtual-channel statistics monitor for the CSI-2 receive path, the parametrised successor of the single-stream statistics accumulator. It counts packet-header, corrected-header and CRC errors and tracks line length, lines per frame and completed frames independently for each virtual channel. It sits beside the video output of the receiver and feeds the CSR block through a per-VC readback multiplexer.

## Interface
- CNT_WIDTH, 32: width of every counter and statistic (min 8).
- VC_CNT, 4: number of tracked virtual channels, 1..4.
- ERR_DLY, 2: register stages on error pulses before counting, 1..4.
- VC_W, derived: max(1, $clog2(VC_CNT)).

- clk_i  in  1  clock.
- srst_i  in  1  reset; asynchronous, active-high.
- video_data_val_i  in  1  pixel beat valid.
- video_proc_ready_i  in  1  downstream ready; beat accepted when valid && ready.
- video_eol_i  in  1  beat is last pixel of line.
- video_frame_start_i  in  1  beat is first pixel of frame.
- video_vc_i  in  VC_W  virtual channel of the beat.
- header_err_i, corr_header_err_i, crc_err_i  in  1 each  single-cycle error pulses.
- clear_stat_i  in  1  synchronous clear of all statistics.
- stat_vc_sel_i  in  VC_W  VC selected for readback.
- snapshot_i  in  1  capture request (see Configuration).
- header_err_cnt_o, corr_header_err_cnt_o, crc_err_cnt_o  out  CNT_WIDTH  global error counts.
- max_px_per_ln_o, min_px_per_ln_o, max_ln_per_frame_o, min_ln_per_frame_o, frame_cnt_o  out  CNT_WIDTH  statistics of selected VC.

## Operation
- Accepted beat = video_data_val_i && video_proc_ready_i; all video logic ignores non-accepted cycles and beats with video_vc_i >= VC_CNT.
- Per VC: px_cnt, ln_cnt, frame_seen flag, max/min px, max/min ln, frame_cnt.
- Accepted beat with eol: line length L = px_cnt+1; max_px = max(max_px, L); min_px = min(min_px, L); px_cnt <= 0. Otherwise px_cnt <= px_cnt+1.
- Accepted beat with frame_start: if frame_seen, record ln_cnt into max_ln/min_ln and frame_cnt+1; then frame_seen <= 1, ln_cnt <= (eol ? 1 : 0). Without frame_start, eol gives ln_cnt+1.
- First frame after reset/clear records nothing (partial frame).
- Error pulses pass through ERR_DLY-stage pipes. header_err_cnt +1 on delayed header_err; corr_header_err_cnt +1 on delayed corr_header_err independent of header_err; crc_err_cnt +1 on delayed crc_err.
- All counters and statistics saturate at all-ones; no wrap.
- clear_stat_i: error counters, max stats, frame_cnt -> 0; min stats -> all-ones; frame_seen -> 0; error pipes flushed. Clear wins over any simultaneous update. px_cnt/ln_cnt keep running.
- Readback: per-VC stats muxed by stat_vc_sel_i into output registers; sel >= VC_CNT returns zeros.

## Timing
- Reset: error counts, max stats, frame_cnt, internal counters 0; min stats all-ones (outputs show selected VC: min = all-ones, others 0); frame_seen 0.
- Reset mid-frame: everything returns to reset values immediately; no partial record.
- Error pulse sampled at edge k -> counter output changes at edge k+ERR_DLY (pipe) then visible after next edge: total ERR_DLY+1 cycles.
- Video stat updated on the edge accepting the beat; per-VC output 1 cycle later (readback register). stat_vc_sel_i change -> outputs after 1 cycle.
- Back-to-back error pulses each counted.

## Configuration
- CSI2_STAT_SNAPSHOT_EN defined: all eight outputs come from a shadow register bank; snapshot_i high loads it on the next edge with current counts (readback mux value for per-VC fields), held until next snapshot_i; reset loads reset values; clear_stat_i does not touch the shadow.
- Undefined: outputs are live (timing above), snapshot_i ignored.

## Test plan
- VC0: 3 frames of 4 lines x 10 px, then 4th frame_start -> max/min_px 10/10, max/min_ln 4/4, frame_cnt 3 (first frame included from 2nd start).
- Interleave VC1 lines of 6 px with VC0 lines of 10 px, 2 lines each per frame -> sel 0 gives px 10, sel 1 gives px 6, no cross-contamination.
- Lines of 5,12,8 px on VC2 -> max_px 12, min_px 5; clear_stat_i -> max 0, min all-ones, next 1-px line (frame_start+eol same beat) -> min 1.
- header_err pulse at edge k with ERR_DLY=2 -> header_err_cnt 1 at k+3; simultaneous corr_header_err and crc_err -> each counter 1.
- CNT_WIDTH=8, 300 crc_err pulses -> crc_err_cnt 255; clear coincident with pulse -> 0.
- CSI2_STAT_SNAPSHOT_EN: snapshot, then 5 more errors -> outputs unchanged until next snapshot_i, then +5.
